// File: rtl/uart_receiver.sv
// UART receive path: 2-flop synchroniser, 16x-oversampled frame FSM, and the
// byte/flag hand-off (start, 8 data bits MSB first, odd parity, stop).
module uart_receiver #(
   parameter int OVERSAMPLE = 16,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_tick,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } state_t;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       bit_idx, idx_nxt;
   logic [7:0]       shreg, shreg_nxt;
   logic             par_bit, par_nxt;
   logic [7:0]       data_nxt;
   logic             perr_nxt, ferr_nxt, valid_nxt;
   logic             rx_m, rx_s;
   logic             bit_end;

   // Synchroniser resets to the idle-line level so reset never looks like a start bit.
   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         data       <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         data_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         bit_idx    <= idx_nxt;
         shreg      <= shreg_nxt;
         par_bit    <= par_nxt;
         data       <= data_nxt;
         parity_err <= perr_nxt;
         frame_err  <= ferr_nxt;
         data_valid <= valid_nxt;
      end
   end

   assign bit_end = (cnt == FULL_LAST);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = bit_idx;
      shreg_nxt = shreg;
      par_nxt   = par_bit;
      data_nxt  = data;
      perr_nxt  = parity_err;
      ferr_nxt  = frame_err;
      valid_nxt = 1'b0;

      if (uart_tick) begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_nxt = START;
                  cnt_nxt   = '0;
               end
            end
            START: begin
               // Re-check the line at mid start bit; a high level here was a glitch.
               if (cnt == HALF_LAST) begin
                  cnt_nxt = '0;
                  idx_nxt = '0;
                  state_nxt = rx_s ? IDLE : DATA;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            DATA: begin
               cnt_nxt = bit_end ? '0 : cnt + CNT_W'(1);
               if (bit_end) begin
                  shreg_nxt = {shreg[6:0], rx_s};
                  idx_nxt   = bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state_nxt = PARITY;
               end
            end
            PARITY: begin
               cnt_nxt = bit_end ? '0 : cnt + CNT_W'(1);
               if (bit_end) begin
                  par_nxt   = rx_s;
                  state_nxt = STOP;
               end
            end
            STOP: begin
               cnt_nxt = bit_end ? '0 : cnt + CNT_W'(1);
               if (bit_end) begin
                  data_nxt  = shreg;
                  perr_nxt  = ~(^shreg ^ par_bit);
                  ferr_nxt  = ~rx_s;
                  valid_nxt = 1'b1;
                  // A low stop bit may be a break; wait for the line to return high.
                  state_nxt = rx_s ? IDLE : WAIT_IDLE;
               end
            end
            WAIT_IDLE: begin
               if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive-side counterpart of the lab UART transmit path.
- Deserialises the 11-bit frame: start bit (0), 8 data bits MSB first, parity bit, stop bit (1).
- Parity rule: the parity bit is 1 when the data byte has an even count of ones, so the total count of ones over data plus parity is odd.
- Runs on the system clock, uses a 16x-baud sample strobe, and hands each received byte with error flags to downstream display/LED logic.

Parameters:
- OVERSAMPLE, 16: sample strobes per bit period. Must be an even value ≥ 4.
- CNT_W, 4: width of the sample counter. Must satisfy 2^CNT_W ≥ OVERSAMPLE.

Ports:
- clk  input  1  system clock; all logic is on posedge.
- rst  input  1  asynchronous, active-high reset.
- uart_tick  input  1  single-clk-cycle strobe at OVERSAMPLE x baud, synchronous to clk.
- rx  input  1  serial line, asynchronous to clk, idle high.
- data  output  8  last received byte.
- data_valid  output  1  one-clk pulse at frame end.
- parity_err  output  1  parity check result of the last frame.
- frame_err  output  1  stop bit of the last frame was 0.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset and clocking:
  - One clock (clk). Reset rst is asynchronous, active-high.
  - Reset values: data=0, data_valid=0, parity_err=0, frame_err=0, busy=0, FSM=IDLE, synchroniser flops=1, counters=0.
- Synchroniser: rx passes through a 2-flop synchroniser reset to 1. Only the synchronised rx_s is used internally.
- Sampling: all FSM sampling and counting advance only on clk edges where uart_tick=1. Between ticks the state holds.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE:
  - Stay while rx_s=1.
  - A tick with rx_s=0 → START, with sample counter cleared.
- START:
  - Count ticks to OVERSAMPLE/2-1 (mid-bit).
  - At mid-bit, rx_s=0 → DATA, with counter and bit index cleared.
  - At mid-bit, rx_s=1 → IDLE (glitch rejection). No flags change.
- DATA:
  - Every OVERSAMPLE ticks, sample rx_s and shift it into the shift register from the LSB side, so the first bit lands in data[7].
  - After the 8th sample → PARITY.
- PARITY: after OVERSAMPLE ticks, capture the parity bit → STOP.
- STOP: after OVERSAMPLE ticks, sample the stop bit, then on that same clk edge:
  - data ← shift register.
  - parity_err ← (XOR of 8 data bits XOR parity bit) == 0.
  - frame_err ← ~rx_s.
  - data_valid=1 for exactly this one clk cycle.
  - Next state: IDLE if the stop bit is 1, else WAIT_IDLE.
- WAIT_IDLE: hold until a tick sees rx_s=1, then → IDLE. This prevents a break condition from being taken as a new start bit.
- Output flag timing:
  - data, parity_err and frame_err are updated only at frame end and hold until the next frame end.
  - A frame is delivered even when errors are flagged.
- Latency: data_valid rises on the clk edge of the mid-stop-bit tick. Line-to-sample delay is 2 clk cycles (synchroniser) plus up to 1 tick of start-edge detection jitter.
- Counter arithmetic: the counter wraps to 0 at OVERSAMPLE-1 in DATA, PARITY and STOP.
- busy: high in every state other than IDLE.
- Boundary conditions:
  - A new start edge arriving in the same tick as the STOP-to-IDLE transition is detected on the next tick. At most 1 tick of phase error, within tolerance.
  - Reset asserted mid-frame aborts immediately to reset values. The partial frame is discarded and data_valid is not pulsed.
  - uart_tick stuck at 0 freezes the FSM with no output change.
  - uart_tick held continuously high is legal; the block then operates at clk/OVERSAMPLE baud.

Test Plan:
- Reset, then send 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1,1) → exactly one data_valid pulse, data=0xA5, parity_err=0, frame_err=0, busy low after the stop bit.
- Send 0x07 with parity bit 0, then 0x07 with parity bit 1 → first frame: data=0x07, parity_err=0. Second frame: data=0x07, parity_err=1.
- Send 0x3C with stop bit 0, hold rx low for 3 bit times, then release, then send 0x81 (parity 1) → first frame: data_valid with frame_err=1 and no spurious frame during the low hold. Then 0x81 received with frame_err=0.
- Drive rx low for 4 ticks only (glitch), then back high → no data_valid, busy returns to 0 within 8 ticks, all outputs unchanged.
- Assert rst during the DATA state of a frame for 0xFF, then deassert and send 0x5A (parity 1) → no pulse for the aborted frame. Next pulse carries data=0x5A with both error flags 0.
- Send back-to-back frames 0x00 (parity 1) and 0xFF (parity 1) with zero idle time between them → two pulses, data values 0x00 then 0xFF, no errors.
